// File: rtl/router_port_ctrl_if.sv
// -----------------------------------------------------------------------------
// router_port_ctrl_if
//
// Purpose:
//   Groups every non-clock, non-reset signal of the router output-port
//   controller. One side is the input FSM plus the three output FIFOs, and
//   the other side is router_port_ctrl.
//
// Signals (named from the controller's point of view):
//   detect_add      in   header-decode strobe; latch data_in as destination
//   data_in         in   destination address from the header byte
//   write_enb_reg   in   input FSM requests a byte write to the destination
//   read_enb        in   per-port downstream read enables
//   empty           in   per-port FIFO empty flags
//   full            in   per-port FIFO full flags
//   clr_sticky      in   clears timeout_sticky
//   write_enb       out  one-hot FIFO write enables
//   fifo_full       out  full flag of the latched destination
//   addr_valid      out  latched destination is a legal port
//   vld_out         out  per-port data-available flags
//   soft_reset      out  one-cycle per-port flush pulses
//   timeout_sticky  out  sticky record of flushes
//
// Modports:
//   slave   the controller itself
//   master  the surrounding logic (input FSM / FIFOs / testbench)
// -----------------------------------------------------------------------------
interface router_port_ctrl_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 detect_add;
    logic [ADDR_W-1:0]    data_in;
    logic                 write_enb_reg;
    logic [NUM_PORTS-1:0] read_enb;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic                 clr_sticky;

    logic [NUM_PORTS-1:0] write_enb;
    logic                 fifo_full;
    logic                 addr_valid;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic [NUM_PORTS-1:0] timeout_sticky;

    modport slave (
        input  detect_add,
        input  data_in,
        input  write_enb_reg,
        input  read_enb,
        input  empty,
        input  full,
        input  clr_sticky,
        output write_enb,
        output fifo_full,
        output addr_valid,
        output vld_out,
        output soft_reset,
        output timeout_sticky
    );

    modport master (
        output detect_add,
        output data_in,
        output write_enb_reg,
        output read_enb,
        output empty,
        output full,
        output clr_sticky,
        input  write_enb,
        input  fifo_full,
        input  addr_valid,
        input  vld_out,
        input  soft_reset,
        input  timeout_sticky
    );
endinterface

// File: rtl/router_port_ctrl.sv
// -----------------------------------------------------------------------------
// router_port_ctrl
//
// Purpose:
//   Per-packet output-port controller of the mini-router. It has four jobs:
//   - Latches the destination address on every header.
//   - Steers the input FSM's write strobe to exactly one output FIFO.
//   - Reports per-port data-valid and the selected FIFO's full flag.
//   - Runs an independent read-timeout watchdog per port. When a port holds
//     unread data for TIMEOUT consecutive cycles, the watchdog pulses that
//     port's soft_reset so the FIFO flushes itself.
//
// Parameters:
//   NUM_PORTS  number of output FIFOs (legal addresses 0..NUM_PORTS-1)
//   ADDR_W     width of the destination address field
//   TIMEOUT    consecutive idle-valid cycles before a flush
//   CNT_W      timeout counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clock   system clock, all state updates on the rising edge
//   resetn  synchronous, active-low reset
//   bus     router_port_ctrl_if.slave, which carries all handshake and flag
//           signals
// -----------------------------------------------------------------------------
module router_port_ctrl #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TIMEOUT   = 30,
    parameter int CNT_W     = 5
) (
    input  logic                 clock,
    input  logic                 resetn,
    router_port_ctrl_if.slave    bus
);

    // The address is zero-extended by one bit before the legality compare.
    // This keeps the compare correct even when NUM_PORTS == 2**ADDR_W.
    localparam logic [ADDR_W:0]  NUM_PORTS_EXT = NUM_PORTS[ADDR_W:0];
    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0]    dest;
    logic                 addr_valid_q;
    logic [NUM_PORTS-1:0] port_sel;

    logic [CNT_W-1:0]     idle_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] idle;
    logic [NUM_PORTS-1:0] timeout_hit;
    logic [NUM_PORTS-1:0] soft_reset_q;
    logic [NUM_PORTS-1:0] timeout_sticky_q;

    // -------------------------------------------------------------------------
    // Destination latch
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dest         <= '0;
            addr_valid_q <= 1'b0;
        end else if (bus.detect_add) begin
            dest         <= bus.data_in;
            addr_valid_q <= ({1'b0, bus.data_in} < NUM_PORTS_EXT);
        end
    end

    // -------------------------------------------------------------------------
    // Destination decode
    // -------------------------------------------------------------------------
    // port_sel is a one-hot copy of the latched destination. It is gated
    // with addr_valid, so an illegal address never selects a port. Both the
    // write steering and the full-flag mux use this one decode. This avoids
    // indexing full[] with an out-of-range address.
    always_comb begin
        port_sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_sel[i] = addr_valid_q && (dest == ADDR_W'(i));
        end
    end

    // Steering uses the already-latched destination. A header and a write
    // in the same cycle therefore still go to the previous destination.
    // write_enb is not masked while a port is flushing, because the FIFO
    // itself gives soft_reset priority.
    assign bus.write_enb  = bus.write_enb_reg ? port_sel : '0;
    assign bus.fifo_full  = |(bus.full & port_sel);
    assign bus.addr_valid = addr_valid_q;
    assign bus.vld_out    = ~bus.empty;

    // -------------------------------------------------------------------------
    // Watchdog qualifiers
    // -------------------------------------------------------------------------
    // A port is idle when it holds data that nobody is reading. A timeout
    // fires on the edge that closes the TIMEOUT-th consecutive idle cycle.
    always_comb begin
        idle        = '0;
        timeout_hit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idle[i]        = ~bus.empty[i] & ~bus.read_enb[i];
            timeout_hit[i] = idle[i] && (idle_cnt[i] == TIMEOUT_LAST);
        end
    end

    // -------------------------------------------------------------------------
    // Per-port timeout counters and flush pulse
    // -------------------------------------------------------------------------
    // Each counter restarts from zero after a flush. This guarantees another
    // full TIMEOUT idle cycles before the next pulse. Writes into the port do
    // not affect its counter; only reads or an empty FIFO clear it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                idle_cnt[i] <= '0;
            end
            soft_reset_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (timeout_hit[i]) begin
                    idle_cnt[i]     <= '0;
                    soft_reset_q[i] <= 1'b1;
                end else if (idle[i]) begin
                    idle_cnt[i]     <= idle_cnt[i] + 1'b1;
                    soft_reset_q[i] <= 1'b0;
                end else begin
                    idle_cnt[i]     <= '0;
                    soft_reset_q[i] <= 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky flush record
    // -------------------------------------------------------------------------
    // clr_sticky wipes the record. If a new timeout arrives in the same
    // cycle, that port's bit is still set.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            timeout_sticky_q <= '0;
        end else begin
            timeout_sticky_q <= timeout_hit |
                                (timeout_sticky_q & {NUM_PORTS{~bus.clr_sticky}});
        end
    end

    assign bus.soft_reset     = soft_reset_q;
    assign bus.timeout_sticky = timeout_sticky_q;

endmodule

// File: tb/tb_router_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_port_ctrl
//
// Purpose:
//   Self-checking directed bench for router_port_ctrl with NUM_PORTS=3,
//   ADDR_W=2 and TIMEOUT=30. Inputs change 2 time units after a rising edge.
//   Outputs are checked 1 unit after that, well away from the edge.
// -----------------------------------------------------------------------------
module tb_router_port_ctrl;

    logic clock;
    logic resetn;

    int total;
    int bad;
    logic [2:0] pulse_seen;

    router_port_ctrl_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();

    router_port_ctrl #(
        .NUM_PORTS (3),
        .ADDR_W    (2),
        .TIMEOUT   (30),
        .CNT_W     (5)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive every input of the controller at once, then let
    // combinational outputs settle before anything is checked.
    task automatic applyStimulus(input logic det, input logic [1:0] din,
                                 input logic wr, input logic [2:0] rd,
                                 input logic [2:0] emp, input logic [2:0] fl,
                                 input logic clr);
        bus.detect_add    = det;
        bus.data_in       = din;
        bus.write_enb_reg = wr;
        bus.read_enb      = rd;
        bus.empty         = emp;
        bus.full          = fl;
        bus.clr_sticky    = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        pulse_seen = '0;
        resetn     = 1'b0;
        applyStimulus(1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b000, 1'b0);

        // ---------------- reset state ----------------
        tick();
        tick();
        checkOutput("rst_addr_valid", {7'd0, bus.addr_valid}, 8'd0);
        checkOutput("rst_write_enb", {5'd0, bus.write_enb}, 8'd0);
        checkOutput("rst_fifo_full", {7'd0, bus.fifo_full}, 8'd0);
        checkOutput("rst_soft_reset", {5'd0, bus.soft_reset}, 8'd0);
        checkOutput("rst_sticky", {5'd0, bus.timeout_sticky}, 8'd0);
        checkOutput("rst_vld_out", {5'd0, bus.vld_out}, 8'd0);

        // ---------------- header to port 1, four writes ----------------
        resetn = 1'b1;
        applyStimulus(1'b1, 2'd1, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0);
        checkOutput("pre_latch_we", {5'd0, bus.write_enb}, 8'd0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b000, 1'b0);
        checkOutput("p1_addr_valid", {7'd0, bus.addr_valid}, 8'd1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("p1_write_%0d", k), {5'd0, bus.write_enb}, 8'h02);
            tick();
            #1;
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0);
        checkOutput("p1_write_off", {5'd0, bus.write_enb}, 8'd0);

        // Header and write in the same cycle: the old destination still wins.
        applyStimulus(1'b1, 2'd2, 1'b1, 3'b000, 3'b111, 3'b000, 1'b0);
        checkOutput("same_cyc_old_dest", {5'd0, bus.write_enb}, 8'h02);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b000, 1'b0);
        checkOutput("same_cyc_new_dest", {5'd0, bus.write_enb}, 8'h04);

        // ---------------- illegal address 3 ----------------
        applyStimulus(1'b1, 2'd3, 1'b0, 3'b000, 3'b111, 3'b111, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b111, 1'b0);
        checkOutput("bad_addr_valid", {7'd0, bus.addr_valid}, 8'd0);
        checkOutput("bad_addr_we", {5'd0, bus.write_enb}, 8'd0);
        checkOutput("bad_addr_full", {7'd0, bus.fifo_full}, 8'd0);

        // ---------------- fifo_full follows the destination ----------------
        applyStimulus(1'b1, 2'd2, 1'b0, 3'b000, 3'b111, 3'b100, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b100, 1'b0);
        checkOutput("full_dest2", {7'd0, bus.fifo_full}, 8'd1);
        applyStimulus(1'b1, 2'd0, 1'b0, 3'b000, 3'b111, 3'b100, 1'b0);
        checkOutput("full_before_relatch", {7'd0, bus.fifo_full}, 8'd1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b100, 1'b0);
        checkOutput("full_dest0", {7'd0, bus.fifo_full}, 8'd0);

        // ---------------- port 0 times out after 30 idle cycles ----------------
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0);
        checkOutput("vld_port0", {5'd0, bus.vld_out}, 8'h01);
        pulse_seen = '0;
        for (int k = 1; k < 30; k++) begin
            tick();
            pulse_seen |= bus.soft_reset;
        end
        checkOutput("to0_no_early_pulse", {5'd0, pulse_seen}, 8'd0);
        tick();
        checkOutput("to0_pulse", {5'd0, bus.soft_reset}, 8'h01);
        checkOutput("to0_sticky", {5'd0, bus.timeout_sticky}, 8'h01);
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0);
        tick();
        checkOutput("to0_pulse_one_cycle", {5'd0, bus.soft_reset}, 8'd0);
        checkOutput("to0_sticky_hold", {5'd0, bus.timeout_sticky}, 8'h01);
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0);
        checkOutput("to0_sticky_clr", {5'd0, bus.timeout_sticky}, 8'd0);

        // ---------------- a read at count 29 prevents the pulse ----------------
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0);
        pulse_seen = '0;
        for (int k = 1; k < 30; k++) begin
            tick();
            pulse_seen |= bus.soft_reset;
        end
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b001, 3'b110, 3'b000, 1'b0);
        tick();
        pulse_seen |= bus.soft_reset;
        checkOutput("rd_saves_no_pulse", {5'd0, pulse_seen}, 8'd0);
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b110, 3'b000, 1'b0);
        for (int k = 1; k < 30; k++) begin
            tick();
            pulse_seen |= bus.soft_reset;
        end
        checkOutput("rd_restart_no_early", {5'd0, pulse_seen}, 8'd0);
        // A clear in the same cycle as a new timeout leaves that bit set.
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b110, 3'b000, 1'b1);
        tick();
        checkOutput("rd_restart_pulse", {5'd0, bus.soft_reset}, 8'h01);
        checkOutput("clr_vs_new_timeout", {5'd0, bus.timeout_sticky}, 8'h01);
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0);
        tick();

        // ---------------- ports 0 and 2, reset mid-count ----------------
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b010, 3'b000, 1'b0);
        checkOutput("vld_ports02", {5'd0, bus.vld_out}, 8'h05);
        pulse_seen = '0;
        for (int k = 1; k < 20; k++) begin
            tick();
            pulse_seen |= bus.soft_reset;
        end
        resetn = 1'b0;
        tick();
        pulse_seen |= bus.soft_reset;
        checkOutput("mid_rst_sticky", {5'd0, bus.timeout_sticky}, 8'd0);
        resetn = 1'b1;
        // If the counters were not cleared, the pulse would come after about
        // 11 more cycles. Cleared counters need 30 cycles.
        for (int k = 1; k < 30; k++) begin
            tick();
            pulse_seen |= bus.soft_reset;
        end
        checkOutput("mid_rst_no_pulse", {5'd0, pulse_seen}, 8'd0);
        tick();
        checkOutput("dual_pulse", {5'd0, bus.soft_reset}, 8'h05);
        checkOutput("dual_sticky", {5'd0, bus.timeout_sticky}, 8'h05);
        applyStimulus(1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 1'b0);
        tick();
        checkOutput("dual_pulse_end", {5'd0, bus.soft_reset}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
